// File: rtl/gf2_poly_divider_seq.sv
// Bit-serial GF(2) polynomial long divider: dividend = quotient*divisor ^ remainder.
// The divisor is normalised to the MSB first, then one quotient bit is produced per cycle.
module gf2_poly_divider_seq #(
  parameter int DW = 51,
  parameter int VW = 26
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-2:0] remainder,
  output logic          div_by_zero
);

  localparam int SW = $clog2(VW);
  localparam int CW = $clog2(DW + 1);
  localparam int unsigned BASE = DW - VW + 1;

  typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] rem_reg, rem_nx, rem_shr;
  logic [DW-1:0] q_reg, q_nx;
  logic [VW-1:0] d_reg;
  logic [SW-1:0] sh;
  logic [CW-1:0] cnt, n_len;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Iteration count N = DW - deg(d); also the shift that right-justifies the remainder.
  assign n_len = CW'(BASE) + CW'(sh);

  always_comb begin
    rem_nx = rem_reg;
    if (rem_reg[DW-1]) rem_nx = rem_reg ^ {d_reg, {(DW-VW){1'b0}}};
    rem_nx  = rem_nx << 1;
    q_nx    = {q_reg[DW-2:0], rem_reg[DW-1]};
    rem_shr = rem_nx >> n_len;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = (divisor == '0) ? DONE : NORM;
      NORM: if (d_reg[VW-1]) state_nx = DIV;
      DIV:  if (cnt == CW'(1)) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_reg     <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      sh          <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            rem_reg     <= dividend;
            d_reg       <= divisor;
            sh          <= '0;
            q_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= (divisor == '0);
          end
        end
        NORM: begin
          if (d_reg[VW-1]) begin
            cnt <= n_len;
          end else begin
            d_reg <= d_reg << 1;
            if (sh != SW'(VW-1)) sh <= sh + 1'b1;
          end
        end
        DIV: begin
          rem_reg <= rem_nx;
          q_reg   <= q_nx;
          cnt     <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            quotient  <= q_nx;
            remainder <= rem_shr[VW-2:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
